uart_tx: RTL and testbench

UART transmit side for the 64-bit slice link. It accepts one FRAME_WIDTH-bit word over an AXI-Stream slave interface and serialises it onto tx. The frame is one start bit (0), then FRAME_WIDTH data bits LSB-first, then STOP_BITS stop bits (1). It is the peer of the link's UART receiver and must be bit-compatible with it at identical TICKS_PER_BIT/FRAME_WIDTH.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: accepts one AXI-Stream word and sends it as a start bit,
// FRAME_WIDTH data bits LSB-first and STOP_BITS stop bits, with tx driven from a flop.
module uart_tx #(
  parameter int TICKS_PER_BIT = 87,
  parameter int FRAME_WIDTH   = 64,
  parameter int STOP_BITS     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] s_axis_tx_tdata,
  input  logic                   s_axis_tx_tvalid,
  output logic                   s_axis_tx_tready,
  output logic                   tx,
  output logic                   tx_busy
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(FRAME_WIDTH + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_next;
  logic [TW-1:0]          r_tick, w_tick_next;
  logic [BW-1:0]          r_bit, w_bit_next;
  logic [FRAME_WIDTH-1:0] r_shift, w_shift_next;
  logic                   r_tx, w_tx_next;
  logic                   w_accept;
  logic                   w_last_tick;

  assign s_axis_tx_tready = (r_state == IDLE) && !rst;
  assign w_accept         = s_axis_tx_tvalid && s_axis_tx_tready;
  assign w_last_tick      = (r_tick == LAST_TICK);
  assign tx               = r_tx;
  assign tx_busy          = (r_state != IDLE);

  // Next-state, counter and shift logic; the bit counter is reused for stop periods.
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE: begin
        w_tick_next = '0;
        w_bit_next  = '0;
        if (w_accept) begin
          w_state_next = START_BIT;
          w_shift_next = s_axis_tx_tdata;
        end else begin
          w_state_next = IDLE;
        end
      end
      START_BIT: begin
        if (w_last_tick) begin
          w_state_next = DATA_BITS;
          w_tick_next  = '0;
        end else begin
          w_tick_next = r_tick + TW'(1);
        end
      end
      DATA_BITS: begin
        if (w_last_tick) begin
          w_tick_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_state_next = STOP_BIT;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end else begin
          w_tick_next = r_tick + TW'(1);
        end
      end
      STOP_BIT: begin
        if (w_last_tick) begin
          w_tick_next = '0;
          if (r_bit == LAST_STOP) begin
            w_state_next = IDLE;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end else begin
          w_tick_next = r_tick + TW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tick_next  = '0;
        w_bit_next   = '0;
      end
    endcase

    // tx is registered from the upcoming state so the line changes with the state.
    case (w_state_next)
      IDLE:      w_tx_next = 1'b1;
      START_BIT: w_tx_next = 1'b0;
      DATA_BITS: w_tx_next = w_shift_next[0];
      STOP_BIT:  w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // State, counters, shift register and line flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table-driven 8-bit frames at 4 ticks/bit plus
// reset and loopback sequences on a default-parameter instance.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic [7:0]  tdata8;
  logic        tvalid8, tready8, tx8, busy8;
  logic [63:0] tdata64;
  logic        tvalid64, tready64, tx64, busy64;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx #(.TICKS_PER_BIT(4), .FRAME_WIDTH(8), .STOP_BITS(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .s_axis_tx_tdata(tdata8), .s_axis_tx_tvalid(tvalid8), .s_axis_tx_tready(tready8),
    .tx(tx8), .tx_busy(busy8)
  );

  uart_tx u_dut64 (
    .clk(clk), .rst(rst),
    .s_axis_tx_tdata(tdata64), .s_axis_tx_tvalid(tvalid64), .s_axis_tx_tready(tready64),
    .tx(tx64), .tx_busy(busy64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: drop tvalid after handshake; 1: keep tvalid, scramble tdata; 2: keep tvalid, present nxt
  task automatic send8(input logic [7:0] d, input logic [9:0] fr, input int mode, input logic [7:0] nxt);
    check("tready_before", tready8, 1'b1);
    tdata8  = d;
    tvalid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (mode == 0) tvalid8 = 1'b0;
    else if (mode == 2) tdata8 = nxt;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("tx d=%h c=%0d", d, c), tx8, fr[c/4]);
      check($sformatf("busy d=%h c=%0d", d, c), busy8, 1'b1);
      check($sformatf("tready d=%h c=%0d", d, c), tready8, 1'b0);
      if (mode == 1) tdata8 = ~tdata8 ^ 8'(c);
      @(negedge clk);
    end
    if (mode == 1) tvalid8 = 1'b0;
    check("tx_idle_after", tx8, 1'b1);
    check("busy_idle_after", busy8, 1'b0);
    check("tready_idle_after", tready8, 1'b1);
  endtask

  // Sends one 64-bit word and decodes the line by mid-bit sampling.
  task automatic send64(input logic [63:0] d);
    logic [63:0] w;
    int k;
    w = '0;
    check("lb_tready", tready64, 1'b1);
    tdata64  = d;
    tvalid64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tvalid64 = 1'b0;
    tdata64  = ~d;
    k = 0;
    while (tx64 !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("lb_start_seen", (k < 10) ? 64'd1 : 64'd0, 64'd1);
    repeat (43) @(negedge clk);
    check("lb_start_mid", tx64, 1'b0);
    for (int i = 0; i < 64; i++) begin
      repeat (87) @(negedge clk);
      w[i] = tx64;
    end
    repeat (87) @(negedge clk);
    check("lb_stop_mid", tx64, 1'b1);
    check("lb_word", w, d);
    repeat (44) @(negedge clk);
    check("lb_busy_done", busy64, 1'b0);
    check("lb_tready_done", tready64, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         mode;
    logic [7:0] nxt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // frame = {stop, data, start}: bit i is the i-th bit period on the wire
    vecs[0] = '{data: 8'hA5, frame: 10'h34A, mode: 0, nxt: 8'h00};
    vecs[1] = '{data: 8'h01, frame: 10'h202, mode: 2, nxt: 8'hFF};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, mode: 0, nxt: 8'h00};
    vecs[3] = '{data: 8'h5A, frame: 10'h2B4, mode: 1, nxt: 8'h00};
    vecs[4] = '{data: 8'hC3, frame: 10'h386, mode: 0, nxt: 8'h00};

    rst      = 1'b1;
    tdata8   = 8'h00;
    tvalid8  = 1'b0;
    tdata64  = 64'h0;
    tvalid64 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx8, 1'b1);
      check("rst_busy", busy8, 1'b0);
      check("rst_tready_held", tready8, 1'b0);
      check("rst_tx64", tx64, 1'b1);
    end
    rst = 1'b0;
    #1;
    check("post_rst_tready", tready8, 1'b1);
    check("post_rst_tready64", tready64, 1'b1);
    @(negedge clk);
    check("idle_tx", tx8, 1'b1);
    check("idle_busy", busy8, 1'b0);

    for (int v = 0; v < 5; v++) begin
      send8(vecs[v].data, vecs[v].frame, vecs[v].mode, vecs[v].nxt);
    end

    // Reset during data bit 3 of 8'h00, then a clean 8'h3C frame.
    tdata8  = 8'h00;
    tvalid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tvalid8 = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_tx_low", tx8, 1'b0);
    check("mid_busy", busy8, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx", tx8, 1'b1);
    check("mid_rst_busy", busy8, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_tready", tready8, 1'b1);
    send8(8'h3C, 10'h278, 0, 8'h00);

    @(negedge clk);
    send64(64'h0123456789ABCDEF);
    send64(64'hFFFFFFFF00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
